// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 frame constants and receiver state encoding
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    localparam logic       START_BIT  = 1'b0;
    localparam logic       STOP_BIT   = 1'b1;
    localparam int         DATA_BITS  = 8;
    localparam logic [7:0] BREAK_CODE = 8'hF0;

endpackage

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - synchroniser, glitch filter and falling-edge pulse for a PS/2 line
module ps2_line_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_i,
    output logic fall_o
);

    localparam int CNT_W = $clog2(FILTER_LEN + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level_q, level_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   fall_q, fall_d;
    logic                   line_s;

    assign line_s = sync_q[SYNC_STAGES-1];
    assign fall_o = fall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '1;
            level_q <= 1'b1;
            cnt_q   <= '0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], line_i};
            level_q <= level_d;
            cnt_q   <= cnt_d;
            fall_q  <= fall_d;
        end
    end

    // Any sample matching the current level restarts the run, so short glitches never accumulate.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        fall_d  = 1'b0;
        if (line_s != level_q) begin
            if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
                level_d = line_s;
                fall_d  = level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_receiver.sv
// rtl/ps2_receiver.sv - PS/2 keyboard frame receiver presenting {previous, latest} byte
// Optional partial-frame timeout enabled by defining PS2_TIMEOUT_EN.
module ps2_receiver #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] code,
    output logic        byte_valid,
    output logic        frame_err
);
    import ps2_pkg::*;

    if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("ps2_receiver: SYNC_STAGES and TIMEOUT_CYCLES must be at least 2");
    end

    ps2_state_e             state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic                   parity_q, parity_d;
    logic [15:0]            code_q, code_d;
    logic                   byte_valid_q, byte_valid_d;
    logic                   frame_err_q, frame_err_d;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic                   data_s;
    logic                   clk_fall;
    logic                   to_expire;
    logic                   frame_ok;

    ps2_line_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_clk_filter (
        .clk    (clk),
        .rst_n  (rst_n),
        .line_i (ps2_clk),
        .fall_o (clk_fall)
    );

    assign data_s     = data_sync_q[SYNC_STAGES-1];
    assign code       = code_q;
    assign byte_valid = byte_valid_q;
    assign frame_err  = frame_err_q;

`ifdef PS2_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES);
    logic [TO_W-1:0] to_cnt_q;

    assign to_expire = (state_q != ST_IDLE) && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            to_cnt_q <= '0;
        else if (state_q == ST_IDLE || clk_fall || to_expire)
            to_cnt_q <= '0;
        else
            to_cnt_q <= to_cnt_q + 1'b1;
    end
`else
    assign to_expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_sync_q  <= '1;
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            code_q       <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            data_sync_q  <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            code_q       <= code_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // A timeout landing on the same cycle as an edge takes priority and drops that edge.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        if (to_expire) begin
            state_d = ST_IDLE;
        end else if (clk_fall) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (data_s == START_BIT) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end
                end
                ST_DATA: begin
                    shift_d   = {data_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'(DATA_BITS - 1))
                        state_d = ST_PARITY;
                end
                ST_PARITY: begin
                    parity_d = data_s;
                    state_d  = ST_STOP;
                end
                ST_STOP: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign frame_ok = (data_s == STOP_BIT) && (^{shift_q, parity_q});

    always_comb begin
        code_d       = code_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        if (to_expire) begin
            frame_err_d = 1'b1;
        end else if (clk_fall && state_q == ST_STOP) begin
            if (frame_ok) begin
                code_d       = {code_q[7:0], shift_q};
                byte_valid_d = 1'b1;
            end else begin
                frame_err_d = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_receiver.sv
// tb/tb_ps2_receiver.sv - self-checking bench for ps2_receiver (table, random and corner sequences)
module tb_ps2_receiver;
    import ps2_pkg::*;

    localparam int FILT       = 4;
    localparam int TB_TIMEOUT = 2000;
    localparam int HALF       = 20;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        ps2_clk  = 1'b1;
    logic        ps2_data = 1'b1;
    logic [15:0] code;
    logic        byte_valid;
    logic        frame_err;

    int          checks    = 0;
    int          failures  = 0;
    int          valid_cnt = 0;
    int          err_cnt   = 0;
    logic [15:0] model_code = 16'h0000;
    logic        prev_v = 1'b0;
    logic        prev_e = 1'b0;

    typedef struct {
        logic [7:0]  b;
        bit          bad_par;
        bit          bad_stop;
        int          glitch_at;
        logic [15:0] exp_code;
    } vec_t;

    vec_t tbl [8];

    always #5 clk = ~clk;

    ps2_receiver #(
        .SYNC_STAGES    (2),
        .FILTER_LEN     (FILT),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .code       (code),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    always @(negedge clk) begin
        if (rst_n && (byte_valid || frame_err)) begin
            checks++;
            if ((byte_valid && frame_err) || (byte_valid && prev_v) || (frame_err && prev_e)) begin
                failures++;
                $display("FAIL pulse_shape: valid=%0b err=%0b prev_valid=%0b prev_err=%0b, required exclusive one-cycle pulses",
                         byte_valid, frame_err, prev_v, prev_e);
            end
            if (byte_valid) valid_cnt++;
            if (frame_err)  err_cnt++;
        end
        prev_v = byte_valid;
        prev_e = frame_err;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic ps2_bit(input logic b, input bit glitch);
        ps2_data = b;
        repeat (HALF / 2) @(negedge clk);
        if (glitch) begin
            ps2_clk = 1'b0;
            repeat (FILT - 1) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (HALF / 2) @(negedge clk);
        end
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (HALF / 2) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int glitch_at, input int nbits);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ bad_par, b, START_BIT};
        for (int i = 0; i < nbits; i++)
            ps2_bit(f[i], i == glitch_at);
        ps2_data = 1'b1;
    endtask

    task automatic run_frame(input string name, input logic [7:0] b, input bit bad_par,
                             input bit bad_stop, input int glitch_at, input logic [15:0] exp_code);
        int v0, e0;
        bit good;
        v0 = valid_cnt;
        e0 = err_cnt;
        send_frame(b, bad_par, bad_stop, glitch_at, 11);
        repeat (10) @(negedge clk);
        good = !bad_par && !bad_stop;
        check({name, " code"}, 32'(code), 32'(exp_code));
        check({name, " valid"}, 32'(valid_cnt - v0), 32'(good));
        check({name, " err"}, 32'(err_cnt - e0), 32'(!good));
    endtask

    initial begin
        int v0, e0, kind;
        logic [7:0] rb;

        tbl[0] = '{8'h45,       1'b0, 1'b0, -1, 16'h0045};
        tbl[1] = '{BREAK_CODE,  1'b0, 1'b0, -1, 16'h45F0};
        tbl[2] = '{8'h16,       1'b0, 1'b0, -1, 16'hF016};
        tbl[3] = '{8'h1E,       1'b1, 1'b0, -1, 16'hF016};
        tbl[4] = '{8'h26,       1'b0, 1'b1, -1, 16'hF016};
        tbl[5] = '{8'h25,       1'b0, 1'b0, -1, 16'h1625};
        tbl[6] = '{BREAK_CODE,  1'b0, 1'b0,  3, 16'h25F0};
        tbl[7] = '{8'h45,       1'b0, 1'b0, -1, 16'hF045};

        repeat (3) @(negedge clk);
        check("reset code", 32'(code), 32'h0);
        check("reset valid", 32'(byte_valid), 32'h0);
        check("reset err", 32'(frame_err), 32'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 8; i++)
            run_frame($sformatf("table[%0d]", i), tbl[i].b, tbl[i].bad_par, tbl[i].bad_stop,
                      tbl[i].glitch_at, tbl[i].exp_code);
        model_code = 16'hF045;

        // idle glitch with data low: a falsely accepted edge would start a frame
        v0 = valid_cnt;
        e0 = err_cnt;
        ps2_data = 1'b0;
        repeat (5) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (FILT - 1) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (10) @(negedge clk);
        ps2_data = 1'b1;
        repeat (20) @(negedge clk);
        model_code = {model_code[7:0], 8'h1C};
        run_frame("after idle glitch", 8'h1C, 1'b0, 1'b0, -1, model_code);
        check("idle glitch no err", 32'(err_cnt - e0), 32'h0);
        check("idle glitch one valid", 32'(valid_cnt - v0), 32'h1);

        for (int n = 0; n < 20; n++) begin
            rb   = 8'($urandom_range(0, 255));
            kind = int'($urandom_range(0, 3));
            if (kind < 2)
                model_code = {model_code[7:0], rb};
            run_frame($sformatf("random[%0d]", n), rb, kind == 2, kind == 3, -1, model_code);
        end

`ifdef PS2_TIMEOUT_EN
        v0 = valid_cnt;
        e0 = err_cnt;
        send_frame(8'hA5, 1'b0, 1'b0, -1, 5);
        repeat (TB_TIMEOUT + 200) @(negedge clk);
        check("timeout err", 32'(err_cnt - e0), 32'h1);
        check("timeout no valid", 32'(valid_cnt - v0), 32'h0);
        check("timeout code", 32'(code), 32'(model_code));
        model_code = {model_code[7:0], 8'h3D};
        run_frame("after timeout", 8'h3D, 1'b0, 1'b0, -1, model_code);
`endif

        send_frame(8'h5A, 1'b0, 1'b0, -1, 5);
        #2 rst_n = 1'b0;
        #1;
        check("midframe reset code", 32'(code), 32'h0);
        check("midframe reset valid", 32'(byte_valid), 32'h0);
        check("midframe reset err", 32'(frame_err), 32'h0);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        model_code = 16'h003D;
        run_frame("after reset", 8'h3D, 1'b0, 1'b0, -1, model_code);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_receiver.md
Name: ps2_receiver

Overview:
PS/2 keyboard front end. It synchronises and filters the raw ps2_clk/ps2_data lines and deserialises 11-bit frames (start, 8 data LSB-first, odd parity, stop). It presents the last two received bytes as a 16-bit code to the scan-code decoder directly downstream. It sits between the board PS/2 pins and the keypad decode logic.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops on each PS/2 line (minimum 2)
FILTER_LEN, 4, consecutive identical synchronised ps2_clk samples required before the filtered level changes
TIMEOUT_CYCLES, 50000, clk cycles without a ps2_clk falling edge before a partial frame is aborted (optional feature only)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
ps2_clk  in  1  raw PS/2 clock pin, idle high, asynchronous to clk
ps2_data  in  1  raw PS/2 data pin, idle high, asynchronous to clk
code  out  16  {previous byte, latest byte}; holds its value between frames
byte_valid  out  1  one-cycle pulse when code has just been updated
frame_err  out  1  one-cycle pulse when a frame is rejected

Behaviour:
- Reset (async): code=16'h0000, byte_valid=0, frame_err=0. Synchroniser and filter state reset to 1 (line idle). FSM in IDLE. Bit counter, shift register and timeout counter cleared. Reset mid-frame discards the partial frame.
- Sync: both lines pass through SYNC_STAGES flops. The filtered clock toggles only after FILTER_LEN equal consecutive samples differ from its current level. Shorter glitches are ignored.
- Sample event: a 1-to-0 transition of the filtered clock produces a one-cycle fall pulse. ps2_data (synchronised) is sampled in the same cycle.
- FSM, advancing only on fall pulses:
  - IDLE: data=0 goes to DATA with bit_cnt=0. data=1 stays in IDLE (spurious edge, no error).
  - DATA: shift data in LSB-first and increment bit_cnt. After the 8th bit, go to PARITY.
  - PARITY: latch the parity bit and go to STOP.
  - STOP: if data=1 and XOR(byte, parity)=1, then code <= {code[7:0], byte} and byte_valid=1. Otherwise frame_err=1 and code is unchanged. Both cases return to IDLE.
- Latency: code, byte_valid and frame_err are registered. They are visible in the cycle after the fall pulse of the stop bit. The pulses last exactly one cycle.
- byte_valid and frame_err are never asserted together.
- A fall pulse in the same cycle as the timeout expiry: the timeout wins, the frame is aborted and the edge is dropped.
- A break sequence F0 then 45 yields code=16'hF045 after the second byte, matching the downstream decoder's expectation.

Optional Feature:
- Macro PS2_TIMEOUT_EN.
- Defined: a counter runs while FSM != IDLE and clears on every fall pulse. When it reaches TIMEOUT_CYCLES-1, the FSM returns to IDLE, frame_err pulses once, the partial byte is discarded and code is unchanged.
- Undefined: no counter is instantiated, and the FSM waits indefinitely for the remaining edges.

Decomposition:
- Package ps2_pkg holds: FSM state encoding (IDLE, DATA, PARITY, STOP), START_BIT=1'b0, STOP_BIT=1'b1, DATA_BITS=8, BREAK_CODE=8'hF0.
- One sub-module, ps2_line_filter: synchroniser, glitch filter and falling-edge pulse for ps2_clk, parameterised by SYNC_STAGES and FILTER_LEN.
- ps2_data uses a plain synchroniser only.

Test Plan:
- Frame 0x45, parity 0, stop 1 -> code=16'h0045, byte_valid high for 1 cycle, frame_err stays 0.
- Frame 0xF0 (parity 1) then frame 0x16 (parity 0) -> code=16'h00F0, then 16'hF016; two byte_valid pulses.
- Frame 0x1E sent with parity 0 (bad) -> frame_err 1-cycle pulse, code unchanged, no byte_valid.
- Frame 0x26 with stop bit 0 -> frame_err pulse, code unchanged. The next good frame 0x25 is accepted and code[7:0]=8'h25.
- ps2_clk low glitch lasting FILTER_LEN-1 clk cycles mid-idle and mid-frame -> no bit sampled; the following valid frame decodes correctly.
- With PS2_TIMEOUT_EN: stop ps2_clk after 4 data bits -> frame_err after TIMEOUT_CYCLES, then frame 0x3D -> code[7:0]=8'h3D.
- Assert rst_n low mid-frame -> all outputs 0 immediately; a fresh frame afterwards decodes normally.
